// File: rtl/uart_frame_seq_if.sv
// Signal bundle between the UART/core harness (master) and the frame sequencer (slave).
interface uart_frame_seq_if #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2
);
  logic [7:0]          RxData;
  logic                RxDone;
  logic                RxEn;
  logic [7:0]          TxData;
  logic                TxEn;
  logic                TxDone;
  logic [IN_BITS-1:0]  OpData;
  logic                Start;
  logic                CoreDone;
  logic [OUT_BITS-1:0] CoreResult;
  logic                Trigger;
  logic                TimedOut;
  logic                Overrun;

  modport master (
    output RxData, RxDone, TxDone, CoreDone, CoreResult,
    input  RxEn, TxData, TxEn, OpData, Start, Trigger, TimedOut, Overrun
  );

  modport slave (
    input  RxData, RxDone, TxDone, CoreDone, CoreResult,
    output RxEn, TxData, TxEn, OpData, Start, Trigger, TimedOut, Overrun
  );
endinterface

// File: rtl/uart_frame_seq.sv
// UART frame sequencer: gathers an operand frame, runs the core with a timeout,
// and serialises the result back out LSB byte first.
module uart_frame_seq #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int TIMEOUT  = 1024
) (
  input logic            Clk,
  input logic            Rst_n,
  uart_frame_seq_if.slave bus
);
  localparam int IN_BYTES  = (IN_BITS + 7) / 8;
  localparam int OUT_BYTES = (OUT_BITS + 7) / 8;
  localparam int SH_W      = IN_BYTES * 8;
  localparam int RS_W      = OUT_BYTES * 8;
  localparam int RC_W      = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
  localparam int TC_W      = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam int CY_W      = $clog2(TIMEOUT);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(IN_BYTES - 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(OUT_BYTES - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RECV = 2'd0,
    S_RUN  = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  // Byte idx of the result, zero-padded above OUT_BITS.
  function automatic logic [7:0] result_byte(input logic [OUT_BITS-1:0] res,
                                             input logic [TC_W-1:0]     idx);
    logic [RS_W-1:0] padded;
    padded                 = '0;
    padded[OUT_BITS-1:0]   = res;
    return padded[{idx, 3'b000} +: 8];
  endfunction

  state_t              r_state;
  logic [RC_W-1:0]     r_rcnt;
  logic [TC_W-1:0]     r_tcnt;
  logic [CY_W-1:0]     r_cyc;
  logic [SH_W-1:0]     r_shadow;
  logic [OUT_BITS-1:0] r_result;
  logic                r_rx_en;
  logic                r_tx_en;
  logic [7:0]          r_tx_data;
  logic [IN_BITS-1:0]  r_op_data;
  logic                r_start;
  logic                r_trigger;
  logic                r_timed_out;
  logic                r_overrun;
  logic [SH_W-1:0]     w_shadow_next;

  always_comb begin
    w_shadow_next                         = r_shadow;
    w_shadow_next[{r_rcnt, 3'b000} +: 8]  = bus.RxData;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state     <= S_RECV;
      r_rcnt      <= '0;
      r_tcnt      <= '0;
      r_cyc       <= '0;
      r_shadow    <= '0;
      r_result    <= '0;
      r_rx_en     <= 1'b0;
      r_tx_en     <= 1'b0;
      r_tx_data   <= 8'h00;
      r_op_data   <= '0;
      r_start     <= 1'b0;
      r_trigger   <= 1'b0;
      r_timed_out <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (bus.RxDone && (r_state != S_RECV)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        S_RECV: begin
          r_rx_en <= 1'b1;
          if (bus.RxDone) begin
            r_shadow <= w_shadow_next;
            if (r_rcnt == RC_LAST) begin
              r_rcnt    <= '0;
              r_op_data <= w_shadow_next[IN_BITS-1:0];
              r_start   <= 1'b1;
              r_trigger <= 1'b1;
              r_rx_en   <= 1'b0;
              r_cyc     <= '0;
              r_state   <= S_RUN;
            end else begin
              r_rcnt <= r_rcnt + RC_W'(1);
            end
          end
        end
        S_RUN: begin
          // A completion in the last timeout cycle wins over the timeout.
          if (bus.CoreDone) begin
            r_result  <= bus.CoreResult;
            r_tx_data <= result_byte(bus.CoreResult, '0);
            r_tx_en   <= 1'b1;
            r_trigger <= 1'b0;
            r_state   <= S_SEND;
          end else if (r_cyc == CY_LAST) begin
            r_result    <= '1;
            r_tx_data   <= result_byte('1, '0);
            r_tx_en     <= 1'b1;
            r_trigger   <= 1'b0;
            r_timed_out <= 1'b1;
            r_state     <= S_SEND;
          end else begin
            r_cyc <= r_cyc + CY_W'(1);
          end
        end
        S_SEND: begin
          if (bus.TxDone) begin
            r_tx_en <= 1'b0;
            if (r_tcnt == TC_LAST) begin
              r_tcnt  <= '0;
              r_rx_en <= 1'b1;
              r_state <= S_RECV;
            end else begin
              r_tcnt  <= r_tcnt + TC_W'(1);
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          r_tx_en   <= 1'b1;
          r_tx_data <= result_byte(r_result, r_tcnt);
          r_state   <= S_SEND;
        end
        default: begin
          r_state   <= S_RECV;
          r_tx_en   <= 1'b0;
          r_trigger <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RxEn     = r_rx_en;
  assign bus.TxEn     = r_tx_en;
  assign bus.TxData   = r_tx_data;
  assign bus.OpData   = r_op_data;
  assign bus.Start    = r_start;
  assign bus.Trigger  = r_trigger;
  assign bus.TimedOut = r_timed_out;
  assign bus.Overrun  = r_overrun;
endmodule

// File: tb/tb_uart_frame_seq.sv
// Scoreboard bench: two sequencer instances (8/2 and 20/12 bits, TIMEOUT=16)
// with responders for the core and the UART transmitter.
module tb_uart_frame_seq;
  logic Clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  always #5 Clk = ~Clk;

  uart_frame_seq_if #(.IN_BITS(8),  .OUT_BITS(2))  bus_a ();
  uart_frame_seq_if #(.IN_BITS(20), .OUT_BITS(12)) bus_b ();

  uart_frame_seq #(.IN_BITS(8), .OUT_BITS(2), .TIMEOUT(16)) dut_a (
    .Clk(Clk), .Rst_n(rst_n_a), .bus(bus_a.slave)
  );
  uart_frame_seq #(.IN_BITS(20), .OUT_BITS(12), .TIMEOUT(16)) dut_b (
    .Clk(Clk), .Rst_n(rst_n_b), .bus(bus_b.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_op_a [$];
  logic [19:0] exp_op_b [$];
  logic [7:0]  exp_tx_a [$];
  logic [7:0]  exp_tx_b [$];

  int          core_dly_a = -1;
  int          core_dly_b = -1;
  logic [1:0]  core_res_a = 2'b00;
  logic [11:0] core_res_b = 12'h000;
  int          tx_hold_a  = 0;
  int          tx_hold_b  = 0;

  int trig_len_a = 0;
  int trig_cnt_a = 0;
  int trig_len_b = 0;
  int trig_cnt_b = 0;
  int gap_cnt_b  = 0;
  int last_gap_b = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name, input string what);
    total = total + 1;
    bad   = bad + 1;
    $display("FAIL %s: %s", name, what);
  endfunction

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d);
    cyc();
    bus_a.RxData = d;
    bus_a.RxDone = 1'b1;
    cyc();
    bus_a.RxDone = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    cyc();
    bus_b.RxData = d;
    bus_b.RxDone = 1'b1;
    cyc();
    bus_b.RxDone = 1'b0;
  endtask

  task automatic wait_idle_a(input string name);
    int n = 0;
    while (!bus_a.RxEn && n < 200) begin
      cyc();
      n++;
    end
    check(name, 64'(bus_a.RxEn), 64'd1);
  endtask

  task automatic wait_idle_b(input string name);
    int n = 0;
    while (!bus_b.RxEn && n < 200) begin
      cyc();
      n++;
    end
    check(name, 64'(bus_b.RxEn), 64'd1);
  endtask

  // Monitor A: operand on Start, TX bytes on TxEn rise, Trigger length.
  initial begin
    logic prev_start = 1'b0;
    logic prev_txen  = 1'b0;
    logic prev_trig  = 1'b0;
    forever begin
      @(negedge Clk);
      if (bus_a.Start) begin
        if (exp_op_a.size() == 0) fail_now("a_op_unexpected", "Start with empty queue");
        else check("a_opdata", 64'(bus_a.OpData), 64'(exp_op_a.pop_front()));
      end
      if (prev_start) check("a_start_pulse", 64'(bus_a.Start), 64'd0);
      if (bus_a.TxEn && !prev_txen) begin
        if (exp_tx_a.size() == 0) fail_now("a_tx_unexpected", "TxEn with empty queue");
        else check("a_txdata", 64'(bus_a.TxData), 64'(exp_tx_a.pop_front()));
      end
      if (bus_a.Trigger) trig_cnt_a++;
      else if (prev_trig) begin
        trig_len_a = trig_cnt_a;
        trig_cnt_a = 0;
      end
      prev_start = bus_a.Start;
      prev_txen  = bus_a.TxEn;
      prev_trig  = bus_a.Trigger;
    end
  end

  // Monitor B: same as A plus the TxEn low gap preceding each byte.
  initial begin
    logic prev_start = 1'b0;
    logic prev_txen  = 1'b0;
    logic prev_trig  = 1'b0;
    forever begin
      @(negedge Clk);
      if (bus_b.Start) begin
        if (exp_op_b.size() == 0) fail_now("b_op_unexpected", "Start with empty queue");
        else check("b_opdata", 64'(bus_b.OpData), 64'(exp_op_b.pop_front()));
      end
      if (prev_start) check("b_start_pulse", 64'(bus_b.Start), 64'd0);
      if (bus_b.TxEn && !prev_txen) begin
        last_gap_b = gap_cnt_b;
        if (exp_tx_b.size() == 0) fail_now("b_tx_unexpected", "TxEn with empty queue");
        else check("b_txdata", 64'(bus_b.TxData), 64'(exp_tx_b.pop_front()));
      end
      if (bus_b.TxEn) gap_cnt_b = 0;
      else gap_cnt_b++;
      if (bus_b.Trigger) trig_cnt_b++;
      else if (prev_trig) begin
        trig_len_b = trig_cnt_b;
        trig_cnt_b = 0;
      end
      prev_start = bus_b.Start;
      prev_txen  = bus_b.TxEn;
      prev_trig  = bus_b.Trigger;
    end
  end

  // Core models: CoreDone core_dly cycles after the Start cycle (never if negative).
  initial forever begin
    @(negedge Clk);
    if (bus_a.Start && core_dly_a >= 0) begin
      if (core_dly_a > 0) begin
        repeat (core_dly_a) @(posedge Clk);
        #1;
      end
      bus_a.CoreResult = core_res_a;
      bus_a.CoreDone   = 1'b1;
      cyc();
      bus_a.CoreDone   = 1'b0;
    end
  end

  initial forever begin
    @(negedge Clk);
    if (bus_b.Start && core_dly_b >= 0) begin
      if (core_dly_b > 0) begin
        repeat (core_dly_b) @(posedge Clk);
        #1;
      end
      bus_b.CoreResult = core_res_b;
      bus_b.CoreDone   = 1'b1;
      cyc();
      bus_b.CoreDone   = 1'b0;
    end
  end

  // UART transmitter models: TxDone some cycles after TxEn is seen.
  initial forever begin
    @(negedge Clk);
    if (bus_a.TxEn) begin
      repeat (tx_hold_a) @(posedge Clk);
      cyc();
      bus_a.TxDone = 1'b1;
      cyc();
      bus_a.TxDone = 1'b0;
    end
  end

  initial forever begin
    @(negedge Clk);
    if (bus_b.TxEn) begin
      repeat (tx_hold_b) @(posedge Clk);
      cyc();
      bus_b.TxDone = 1'b1;
      cyc();
      bus_b.TxDone = 1'b0;
    end
  end

  initial begin
    int n;
    bus_a.RxData = 8'h00; bus_a.RxDone = 1'b0; bus_a.TxDone = 1'b0;
    bus_a.CoreDone = 1'b0; bus_a.CoreResult = 2'b00;
    bus_b.RxData = 8'h00; bus_b.RxDone = 1'b0; bus_b.TxDone = 1'b0;
    bus_b.CoreDone = 1'b0; bus_b.CoreResult = 12'h000;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    repeat (2) cyc();
    check("a_reset_outs", 64'({bus_a.RxEn, bus_a.TxEn, bus_a.TxData, bus_a.OpData,
                               bus_a.Start, bus_a.Trigger, bus_a.TimedOut, bus_a.Overrun}), 64'd0);
    check("b_reset_outs", 64'({bus_b.RxEn, bus_b.TxEn, bus_b.TxData, bus_b.OpData,
                               bus_b.Start, bus_b.Trigger, bus_b.TimedOut, bus_b.Overrun}), 64'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    repeat (2) cyc();
    check("a_rxen_after_reset", 64'(bus_a.RxEn), 64'd1);

    // Default frame: 0xA5, result 2'b10 three cycles after Start.
    core_dly_a = 3; core_res_a = 2'b10;
    exp_op_a.push_back(8'hA5); exp_tx_a.push_back(8'h02);
    send_a(8'hA5);
    check("a_op_t1", 64'(bus_a.OpData), 64'hA5);
    check("a_start_t1", 64'({bus_a.Start, bus_a.Trigger, bus_a.RxEn}), 64'b110);
    cyc();
    check("a_start_t2", 64'(bus_a.Start), 64'd0);
    wait_idle_a("a_frame1_done");
    check("a_trig_len1", 64'(trig_len_a), 64'd4);
    check("a_timedout_clear", 64'(bus_a.TimedOut), 64'd0);

    // Core never answers: RUN lasts 16 cycles, all-ones result.
    core_dly_a = -1;
    exp_op_a.push_back(8'h3C); exp_tx_a.push_back(8'h03);
    send_a(8'h3C);
    wait_idle_a("a_timeout_done");
    check("a_trig_len_timeout", 64'(trig_len_a), 64'd16);
    check("a_timedout_set", 64'(bus_a.TimedOut), 64'd1);

    // Normal frame afterwards: TimedOut stays sticky.
    core_dly_a = 1; core_res_a = 2'b01;
    exp_op_a.push_back(8'h5A); exp_tx_a.push_back(8'h01);
    send_a(8'h5A);
    wait_idle_a("a_after_timeout_done");
    check("a_trig_len_after", 64'(trig_len_a), 64'd2);
    check("a_timedout_sticky", 64'(bus_a.TimedOut), 64'd1);

    rst_n_a = 1'b0;
    cyc();
    check("a_reset2_outs", 64'({bus_a.RxEn, bus_a.TxEn, bus_a.TxData, bus_a.OpData,
                                bus_a.Start, bus_a.Trigger, bus_a.TimedOut, bus_a.Overrun}), 64'd0);
    rst_n_a = 1'b1;
    repeat (2) cyc();

    // CoreDone on the 16th RUN cycle counts as completion.
    core_dly_a = 15; core_res_a = 2'b01;
    exp_op_a.push_back(8'h81); exp_tx_a.push_back(8'h01);
    send_a(8'h81);
    wait_idle_a("a_lastcycle_done");
    check("a_trig_len_last", 64'(trig_len_a), 64'd16);
    check("a_timedout_edge", 64'(bus_a.TimedOut), 64'd0);

    // Stray bytes during RUN and SEND.
    core_dly_a = 5; core_res_a = 2'b10; tx_hold_a = 4;
    exp_op_a.push_back(8'h42); exp_tx_a.push_back(8'h02);
    send_a(8'h42);
    bus_a.RxData = 8'hFF;
    bus_a.RxDone = 1'b1;
    cyc();
    bus_a.RxDone = 1'b0;
    check("a_overrun_run", 64'(bus_a.Overrun), 64'd1);
    n = 0;
    while (!bus_a.TxEn && n < 50) begin
      cyc();
      n++;
    end
    check("a_txen_seen", 64'(bus_a.TxEn), 64'd1);
    bus_a.RxData = 8'hEE;
    bus_a.RxDone = 1'b1;
    cyc();
    bus_a.RxDone = 1'b0;
    check("a_send_held", 64'(bus_a.TxEn), 64'd1);
    wait_idle_a("a_overrun_done");
    tx_hold_a = 0;
    check("a_op_unchanged", 64'(bus_a.OpData), 64'h42);
    check("a_overrun_sticky", 64'(bus_a.Overrun), 64'd1);

    // Next frame after overrun, CoreDone in the Start cycle.
    core_dly_a = 0; core_res_a = 2'b11;
    exp_op_a.push_back(8'h17); exp_tx_a.push_back(8'h03);
    send_a(8'h17);
    wait_idle_a("a_post_overrun_done");
    check("a_trig_len_zero_dly", 64'(trig_len_a), 64'd1);

    // Wide frame: 20-bit operand, 12-bit result over two bytes.
    core_dly_b = 2; core_res_b = 12'hABC;
    exp_op_b.push_back(20'h51234);
    exp_tx_b.push_back(8'hBC); exp_tx_b.push_back(8'h0A);
    send_b(8'h34); send_b(8'h12); send_b(8'hF5);
    check("b_op_t1", 64'(bus_b.OpData), 64'h51234);
    wait_idle_b("b_frame1_done");
    check("b_tx_gap", 64'(last_gap_b), 64'd1);
    check("b_trig_len1", 64'(trig_len_b), 64'd3);

    // Reset after two of three bytes, then a fresh frame.
    send_b(8'h11); send_b(8'h22);
    rst_n_b = 1'b0;
    cyc();
    check("b_midframe_reset_outs", 64'({bus_b.RxEn, bus_b.TxEn, bus_b.TxData, bus_b.OpData,
                                        bus_b.Start, bus_b.Trigger, bus_b.TimedOut, bus_b.Overrun}), 64'd0);
    rst_n_b = 1'b1;
    repeat (2) cyc();
    core_dly_b = 4; core_res_b = 12'h123;
    exp_op_b.push_back(20'h45678);
    exp_tx_b.push_back(8'h23); exp_tx_b.push_back(8'h01);
    send_b(8'h78); send_b(8'h56); send_b(8'hF4);
    wait_idle_b("b_frame2_done");
    check("b_op_fresh", 64'(bus_b.OpData), 64'h45678);
    check("b_tx_gap2", 64'(last_gap_b), 64'd1);

    repeat (3) cyc();
    check("a_op_queue_empty", 64'(exp_op_a.size()), 64'd0);
    check("a_tx_queue_empty", 64'(exp_tx_a.size()), 64'd0);
    check("b_op_queue_empty", 64'(exp_op_b.size()), 64'd0);
    check("b_tx_queue_empty", 64'(exp_tx_b.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
